// File: rtl/vga_rect_filler.sv
// vga_rect_filler: fills an axis-aligned rectangle (start) or the whole
// screen (clear) with one colour, issuing one video-memory write per cycle
// in raster order. Coordinates, colour packing and linear addresses match
// what the VGA controller uses when it scans the same memory.
//
// Ports:
//   vga_clock, resetn          clock, async active-low reset
//   start, clear               fill requests, sampled only while ready=1
//   x0, y0, width, height      rectangle (clipped to the screen)
//   colour                     fill colour, R in MSBs .. B in LSBs
//   ready                      idle, accepting requests
//   done                       one-cycle pulse after the last write
//   plot                       write enable for video memory
//   x_out, y_out, colour_out   current write position and colour
//   mem_address                y_out*XMAX + x_out
module vga_rect_filler #(
  parameter int BITS_PER_COLOUR_CHANNEL = 1,
  parameter     MONOCHROME              = "FALSE",
  parameter     RESOLUTION              = "320x240",
  localparam bit HIRES = (RESOLUTION == "640x480"),
  localparam int XW    = HIRES ? 10 : 9,
  localparam int YW    = HIRES ? 9 : 8,
  localparam int AW    = HIRES ? 19 : 17,
  localparam int CW    = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          vga_clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          clear,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW:0]   width,
  input  logic [YW:0]   height,
  input  logic [CW-1:0] colour,
  output logic          ready,
  output logic          done,
  output logic          plot,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic [AW-1:0] mem_address
);

  localparam int XMAX = HIRES ? 640 : 320;
  localparam int YMAX = HIRES ? 480 : 240;
  // XMAX = 2^a + 2^b, so y*XMAX is two shifted copies of y
  localparam int SH_HI = HIRES ? 9 : 8;
  localparam int SH_LO = HIRES ? 7 : 6;

  localparam logic [XW+1:0] XMAX_W = (XW+2)'(XMAX);
  localparam logic [YW+1:0] YMAX_W = (YW+2)'(YMAX);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          plot_q, plot_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;

  // captured request, immune to input changes while busy
  logic [XW-1:0] cx0_q, cx0_d;
  logic [YW-1:0] cy0_q, cy0_d;
  logic [XW:0]   cw_q, cw_d;
  logic [YW:0]   ch_q, ch_d;
  logic [CW-1:0] ccol_q, ccol_d;
  logic [XW+1:0] x_end_q, x_end_d;
  logic [YW+1:0] y_end_q, y_end_d;

  logic [XW+1:0] x_sum;
  logic [YW+1:0] y_sum;
  logic          empty, x_last, y_last;

  // extra top bit keeps x0+width from wrapping before the clip
  assign x_sum  = {2'b00, cx0_q} + {1'b0, cw_q};
  assign y_sum  = {2'b00, cy0_q} + {1'b0, ch_q};
  assign empty  = (cw_q == '0) || (ch_q == '0) ||
                  ({2'b00, cx0_q} >= XMAX_W) || ({2'b00, cy0_q} >= YMAX_W);
  assign x_last = ({2'b00, x_q} + (XW+2)'(1)) == x_end_q;
  assign y_last = ({2'b00, y_q} + (YW+2)'(1)) == y_end_q;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    cx0_d   = cx0_q;
    cy0_d   = cy0_q;
    cw_d    = cw_q;
    ch_d    = ch_q;
    ccol_d  = ccol_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          cx0_d   = '0;
          cy0_d   = '0;
          cw_d    = (XW+1)'(XMAX);
          ch_d    = (YW+1)'(YMAX);
          ccol_d  = colour;
          state_d = LOAD;
          ready_d = 1'b0;
        end else if (start) begin
          cx0_d   = x0;
          cy0_d   = y0;
          cw_d    = width;
          ch_d    = height;
          ccol_d  = colour;
          state_d = LOAD;
          ready_d = 1'b0;
        end
      end
      LOAD: begin
        x_end_d = (x_sum > XMAX_W) ? XMAX_W : x_sum;
        y_end_d = (y_sum > YMAX_W) ? YMAX_W : y_sum;
        if (empty) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FILL;
          plot_d  = 1'b1;
          x_d     = cx0_q;
          y_d     = cy0_q;
          col_d   = ccol_q;
        end
      end
      FILL: begin
        if (x_last) begin
          if (y_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            plot_d = 1'b1;
            x_d    = cx0_q;
            y_d    = y_q + YW'(1);
          end
        end else begin
          plot_d = 1'b1;
          x_d    = x_q + XW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
    addr_d = (AW'(y_d) << SH_HI) + (AW'(y_d) << SH_LO) + AW'(x_d);
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      cx0_q   <= '0;
      cy0_q   <= '0;
      cw_q    <= '0;
      ch_q    <= '0;
      ccol_q  <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      cx0_q   <= cx0_d;
      cy0_q   <= cy0_d;
      cw_q    <= cw_d;
      ch_q    <= ch_d;
      ccol_q  <= ccol_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign plot        = plot_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign colour_out  = col_q;
  assign mem_address = addr_q;

endmodule
